atm_session_ctrl: RTL and testbench

Front-end session controller for the ATM, sitting directly upstream of the operation-select stage. It accepts a card and its stored PIN, collects PIN digits from the keypad, and enforces a bounded number of attempts with card retention. Once the PIN is verified, it turns menu keypresses into a 2-bit operation choice and hands it downstream over a valid/ready handshake: 00 check balance, 01 withdraw cash, 10 register card, 11 change PIN.

---
 rtl/atm_session_ctrl.sv | 178 +++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/atm_session_ctrl.sv
// ATM session front end: card/PIN verification with retry lockout, then menu keys to a 2-bit operation offer.
// Every output is a flop. The operation offer holds until choice_ready, and the offer is dropped immediately on card removal.
module atm_session_ctrl #(
  parameter int PIN_DIGITS  = 4,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           card_in,
  input  logic [4*PIN_DIGITS-1:0]        card_pin,
  input  logic                           key_valid,
  input  logic [3:0]                     key_code,
  output logic [1:0]                     choice,
  output logic                           choice_valid,
  input  logic                           choice_ready,
  output logic                           authed,
  output logic                           pin_error,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_used,
  output logic                           eject,
  output logic                           card_retain
);

  localparam int BW = 4 * PIN_DIGITS;
  localparam int CW = $clog2(PIN_DIGITS + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int IW = $clog2(TIMEOUT_CYC);

  localparam logic [CW-1:0] CNT_FULL = CW'(PIN_DIGITS);
  localparam logic [TW-1:0] TRY_MAX  = TW'(MAX_TRIES);
  localparam logic [IW-1:0] IDLE_END = IW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]    KEY_ENTER  = 4'hA;
  localparam logic [3:0]    KEY_CANCEL = 4'hB;

  typedef enum logic [2:0] {
    S_IDLE, S_PIN, S_CHECK, S_MENU, S_ISSUE, S_EJECT, S_LOCKED
  } state_t;

  state_t          state_q;
  logic [BW-1:0]   pin_q;
  logic [BW-1:0]   buf_q;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   idle_q;
  logic            in_session;
  logic            timed_out;

  assign in_session = (state_q == S_PIN) || (state_q == S_CHECK) ||
                      (state_q == S_MENU) || (state_q == S_ISSUE);
  assign timed_out  = (idle_q == IDLE_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pin_q        <= '0;
      buf_q        <= '0;
      cnt_q        <= '0;
      idle_q       <= '0;
      choice       <= '0;
      choice_valid <= 1'b0;
      authed       <= 1'b0;
      pin_error    <= 1'b0;
      tries_used   <= '0;
      eject        <= 1'b0;
      card_retain  <= 1'b0;
    end else begin
      pin_error <= 1'b0;
      eject     <= 1'b0;
      // Card removal outranks keys and timeout, including mid-handshake.
      if (!card_in && in_session) begin
        state_q      <= S_IDLE;
        authed       <= 1'b0;
        choice_valid <= 1'b0;
        pin_q        <= '0;
        buf_q        <= '0;
        cnt_q        <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (card_in) begin
              pin_q      <= card_pin;
              buf_q      <= '0;
              cnt_q      <= '0;
              idle_q     <= '0;
              tries_used <= '0;
              state_q    <= S_PIN;
            end
          end
          S_PIN: begin
            if (key_valid) begin
              idle_q <= '0;
              if (key_code <= 4'd9) begin
                if (cnt_q < CNT_FULL) begin
                  buf_q <= (buf_q << 4) | BW'(key_code);
                  cnt_q <= cnt_q + 1'b1;
                end
              end else if (key_code == KEY_ENTER) begin
                state_q <= S_CHECK;
              end else if (key_code == KEY_CANCEL) begin
                state_q <= S_EJECT;
                eject   <= 1'b1;
              end
            end else if (timed_out) begin
              state_q <= S_EJECT;
              eject   <= 1'b1;
            end else begin
              idle_q <= idle_q + 1'b1;
            end
          end
          S_CHECK: begin
            if (cnt_q == CNT_FULL && buf_q == pin_q) begin
              state_q <= S_MENU;
              authed  <= 1'b1;
              idle_q  <= '0;
            end else begin
              pin_error  <= 1'b1;
              tries_used <= tries_used + 1'b1;
              if (tries_used + 1'b1 == TRY_MAX) begin
                state_q     <= S_LOCKED;
                card_retain <= 1'b1;
              end else begin
                buf_q   <= '0;
                cnt_q   <= '0;
                idle_q  <= '0;
                state_q <= S_PIN;
              end
            end
          end
          S_MENU: begin
            if (key_valid) begin
              idle_q <= '0;
              if (key_code >= 4'd1 && key_code <= 4'd4) begin
                choice       <= key_code[1:0] - 2'd1;
                choice_valid <= 1'b1;
                state_q      <= S_ISSUE;
              end else if (key_code == KEY_CANCEL) begin
                state_q <= S_EJECT;
                eject   <= 1'b1;
                authed  <= 1'b0;
              end
            end else if (timed_out) begin
              state_q <= S_EJECT;
              eject   <= 1'b1;
              authed  <= 1'b0;
            end else begin
              idle_q <= idle_q + 1'b1;
            end
          end
          S_ISSUE: begin
            if (choice_ready) begin
              choice_valid <= 1'b0;
              idle_q       <= '0;
              state_q      <= S_MENU;
            end
          end
          S_EJECT: begin
            if (!card_in) begin
              state_q <= S_IDLE;
              pin_q   <= '0;
              buf_q   <= '0;
              cnt_q   <= '0;
            end
          end
          S_LOCKED: begin
            if (!card_in) begin
              state_q     <= S_IDLE;
              card_retain <= 1'b0;
              pin_q       <= '0;
              buf_q       <= '0;
              cnt_q       <= '0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl; operation offers are checked against a queue of expected choices at each handshake.
module tb_atm_session_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        card_in;
  logic [15:0] card_pin;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [1:0]  choice;
  logic        choice_valid;
  logic        choice_ready;
  logic        authed;
  logic        pin_error;
  logic [1:0]  tries_used;
  logic        eject;
  logic        card_retain;

  int vectors = 0;
  int miscompares = 0;
  logic [1:0] sb[$];
  logic [1:0] dropped;
  int first_eject;

  atm_session_ctrl #(.PIN_DIGITS(4), .MAX_TRIES(3), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .card_in(card_in), .card_pin(card_pin),
    .key_valid(key_valid), .key_code(key_code), .choice(choice),
    .choice_valid(choice_valid), .choice_ready(choice_ready), .authed(authed),
    .pin_error(pin_error), .tries_used(tries_used), .eject(eject),
    .card_retain(card_retain)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic measure_eject(output int at);
    at = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (eject && at == 0) at = i;
    end
  endtask

  // Pop the expected operation at every accepted offer.
  always @(posedge clk) begin
    if (rst_n && choice_valid && choice_ready) begin
      chk("hs_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("hs_choice", 32'(choice), 32'(sb.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; card_in = 1'b0; card_pin = 16'h1234;
    key_valid = 1'b0; key_code = 4'h0; choice_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_choice", 32'(choice), 0);
    chk("rst_valid", 32'(choice_valid), 0);
    chk("rst_authed", 32'(authed), 0);
    chk("rst_pin_error", 32'(pin_error), 0);
    chk("rst_tries", 32'(tries_used), 0);
    chk("rst_eject", 32'(eject), 0);
    chk("rst_retain", 32'(card_retain), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Correct PIN, one operation, then cancel.
    card_in = 1'b1;
    @(negedge clk);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hA);
    chk("t1_authed_check", 32'(authed), 0);
    @(negedge clk);
    chk("t1_authed", 32'(authed), 1);
    chk("t1_pin_error", 32'(pin_error), 0);
    sb.push_back(2'b01);
    press(4'd2);
    chk("t1_valid", 32'(choice_valid), 1);
    chk("t1_choice", 32'(choice), 32'h1);
    repeat (3) @(negedge clk);
    chk("t1_valid_held", 32'(choice_valid), 1);
    chk("t1_choice_held", 32'(choice), 32'h1);
    choice_ready = 1'b1;
    @(negedge clk);
    choice_ready = 1'b0;
    chk("t1_valid_drop", 32'(choice_valid), 0);
    chk("t1_menu_authed", 32'(authed), 1);
    press(4'hB);
    chk("t1_eject", 32'(eject), 1);
    chk("t1_cancel_authed", 32'(authed), 0);
    @(negedge clk);
    chk("t1_eject_pulse", 32'(eject), 0);
    first_eject = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (eject) first_eject++;
    end
    chk("t1_eject_hold", 32'(first_eject), 0);
    card_in = 1'b0;
    @(negedge clk);

    // Three wrong PINs retain the card.
    card_in = 1'b1;
    @(negedge clk);
    for (int t = 1; t <= 3; t++) begin
      press(4'd9); press(4'd9); press(4'd9); press(4'd9); press(4'hA);
      @(negedge clk);
      chk("t2_pin_error", 32'(pin_error), 1);
      chk("t2_tries", 32'(tries_used), 32'(t));
      chk("t2_retain", 32'(card_retain), 32'(t == 3));
    end
    @(negedge clk);
    chk("t2_pin_error_pulse", 32'(pin_error), 0);
    repeat (12) @(negedge clk);
    chk("t2_retain_hold", 32'(card_retain), 1);
    chk("t2_no_eject", 32'(eject), 0);
    card_in = 1'b0;
    @(negedge clk);
    chk("t2_retain_release", 32'(card_retain), 0);

    // Short entry fails; an extra digit is ignored and passes.
    card_in = 1'b1;
    @(negedge clk);
    chk("t3_tries_new", 32'(tries_used), 0);
    press(4'd1); press(4'd2); press(4'd3); press(4'hA);
    @(negedge clk);
    chk("t3_short_err", 32'(pin_error), 1);
    chk("t3_short_tries", 32'(tries_used), 1);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5); press(4'hA);
    @(negedge clk);
    chk("t3_long_authed", 32'(authed), 1);
    chk("t3_long_err", 32'(pin_error), 0);
    chk("t3_long_tries", 32'(tries_used), 1);

    // Card pulled during an unaccepted offer.
    sb.push_back(2'b11);
    press(4'd4);
    chk("t5_choice", 32'(choice), 32'h3);
    chk("t5_valid", 32'(choice_valid), 1);
    repeat (2) @(negedge clk);
    card_in = 1'b0;
    @(negedge clk);
    dropped = sb.pop_front();
    chk("t5_abort_valid", 32'(choice_valid), 0);
    chk("t5_abort_authed", 32'(authed), 0);
    card_in = 1'b1;
    @(negedge clk);
    chk("t5_reinsert_tries", 32'(tries_used), 0);

    // Inactivity timeout, then a key restarts the count.
    measure_eject(first_eject);
    chk("t4_timeout_cycle", 32'(first_eject), 8);
    card_in = 1'b0;
    @(negedge clk);
    card_in = 1'b1;
    @(negedge clk);
    repeat (6) @(negedge clk);
    press(4'hC);
    measure_eject(first_eject);
    chk("t4_restart_cycle", 32'(first_eject), 8);
    card_in = 1'b0;
    @(negedge clk);

    // Reset mid-entry clears everything asynchronously.
    card_in = 1'b1;
    @(negedge clk);
    press(4'd1); press(4'd2); press(4'hA);
    @(negedge clk);
    chk("t6_pre_err", 32'(pin_error), 1);
    chk("t6_pre_tries", 32'(tries_used), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_err", 32'(pin_error), 0);
    chk("t6_rst_tries", 32'(tries_used), 0);
    chk("t6_rst_eject", 32'(eject), 0);
    chk("t6_rst_authed", 32'(authed), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hA);
    @(negedge clk);
    chk("t6_new_authed", 32'(authed), 1);
    chk("t6_new_tries", 32'(tries_used), 0);
    card_in = 1'b0;
    @(negedge clk);
    chk("t6_pull_authed", 32'(authed), 0);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
